ramp_adc_capture: RTL and testbench
===================================

Name: ramp_adc_capture

Overview:
Single-slope ADC readout that sits on the receiving end of the 7-bit ramp/frame counter. The counter pulses roll_in once per 128-cycle ramp frame, and this block times how long the external comparator takes to trip within that frame. It resynchronises the asynchronous comparator, converts the trip time into a latency-compensated code, and presents one sample per frame on a valid/ready handshake. Overrange frames and dropped frames are flagged.

Parameters:
WIDTH, 7, code width; the frame length is 2^WIDTH cycles, matching the upstream counter.
SYNC_STAGES, 2, number of flops in the comp_in synchroniser; must be 2 or more.

Ports:
clk  input  1  system clock.
reset_n  input  1  asynchronous active-low reset.
roll_in  input  1  frame pulse from the ramp counter; high for one cycle at terminal count.
comp_in  input  1  analog comparator output, asynchronous; high once ramp >= input.
sample_data  output  WIDTH  converted code; held stable while sample_valid=1.
sample_valid  output  1  sample available.
sample_ready  input  1  consumer accepts the sample when sample_valid & sample_ready.
overrange  output  1  qualifies sample_data; 1 when the comparator never tripped in the frame.
busy  output  1  high in the CONVERT state.
drop_count  output  4  saturating count of frames ignored while in HOLD.

Behaviour:
- Reset (asynchronous, active-low):
  - Values: state=IDLE, synchroniser flops=0, cnt=0, sample_data=0, sample_valid=0, overrange=0, busy=0, drop_count=0.
  - Reset asserted mid-conversion or during HOLD aborts immediately and discards the sample.
- Synchroniser: comp_s is comp_in delayed by a SYNC_STAGES-flop chain. No other logic uses comp_in directly.
- Internal count: WIDTH-bit cnt, incremented only in CONVERT. It saturates at 2^WIDTH-1 and never wraps.
- State machine (IDLE, CONVERT, HOLD):
  - IDLE: when roll_in=1, go to CONVERT with cnt<=0. Otherwise stay.
  - CONVERT: conditions are evaluated in this priority order.
    - roll_in=1 (the frame ended without a trip): capture sample_data=2^WIDTH-1, overrange=1, go to HOLD.
    - Else if comp_s=1: capture sample_data = cnt - SYNC_STAGES, saturating at 0; set overrange=0; go to HOLD.
    - Else: cnt<=cnt+1 (saturating).
  - HOLD: sample_valid=1. sample_data and overrange are held stable.
    - On sample_valid & sample_ready, go to IDLE.
    - If roll_in=1 in the same cycle as the handshake, go directly to CONVERT with cnt<=0. That frame is not counted as dropped.
    - roll_in=1 without the handshake: the frame is dropped, drop_count increments (saturating at 15), and the state stays HOLD.
- Latency and outputs:
  - sample_valid rises the cycle after the capture condition is sampled.
  - sample_valid falls the cycle after the handshake.
  - busy=1 exactly while the state is CONVERT.
  - sample_ready is ignored outside HOLD.
- Comparator already high at frame start: comp_s=1 on the first CONVERT cycle (cnt=0) gives sample_data=0, overrange=0.
- Arithmetic: the subtraction is done at WIDTH+1 bits and clamped to the range 0..2^WIDTH-1. There is no modular wrap.
- Code meaning: with a continuous 128-cycle roll and a comparator edge at cycle k after roll (k=1..127), the resulting code is k-1 for SYNC_STAGES=2. This compensates the synchroniser delay.

Test Plan:
- Reset: assert reset_n=0 asynchronously, mid-CONVERT -> all outputs 0 within the same cycle, no sample_valid afterwards until a new roll_in.
- Nominal: roll_in at t0, comp_in rises at t0+41 and stays high, sample_ready=1 -> sample_valid is high for exactly one cycle with sample_data=40, overrange=0.
- Overrange: roll_in at t0, comp_in held 0, next roll_in at t0+128 -> sample_data=127, overrange=1. The second roll_in is consumed as the frame end, not as a start; the next frame starts on the following roll_in.
- Immediate trip: comp_in held 1 before roll_in -> sample_data=0, overrange=0.
- Backpressure and drops: sample_ready=0 across 20 frame pulses while in HOLD -> sample_data stays stable, drop_count saturates at 15. Raising sample_ready completes the handshake, then the block returns to IDLE.
- Simultaneous events: handshake and roll_in in the same cycle -> busy=1 next cycle, cnt restarts at 0, drop_count unchanged. Separately, roll_in and comp_s both high in CONVERT -> overrange result (roll_in has priority).

Source files
------------

// File: rtl/ramp_adc_capture.sv
// Single-slope ADC readout: times the comparator trip within a ramp frame
// and presents one latency-compensated code per frame on valid/ready.
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   roll_in        frame pulse from the ramp counter (terminal count)
//   comp_in        asynchronous comparator output
//   sample_data    converted code, stable while sample_valid
//   sample_valid   sample available
//   sample_ready   consumer accepts on valid & ready
//   overrange      no trip seen during the frame
//   busy           high while converting
//   drop_count     saturating count of frames dropped in HOLD
module ramp_adc_capture #(
  parameter int WIDTH       = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             roll_in,
  input  logic             comp_in,
  output logic [WIDTH-1:0] sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrange,
  output logic             busy,
  output logic [3:0]       drop_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_HOLD
  } state_t;

  localparam logic [WIDTH-1:0] MAXC = '1;
  localparam logic [WIDTH:0]   LAT  = (WIDTH+1)'(SYNC_STAGES);

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [WIDTH-1:0]       r_cnt;
  logic [WIDTH-1:0]       r_data;
  logic                   r_valid;
  logic                   r_ovr;
  logic                   r_busy;
  logic [3:0]             r_drop;

  logic                   w_comp_s;
  logic [WIDTH:0]         w_diff;
  logic [WIDTH-1:0]       w_code;
  logic                   w_hs;

  assign w_comp_s = r_sync[SYNC_STAGES-1];

  // Remove the synchroniser delay from the trip time; clamp at zero
  // when the comparator was already high at frame start.
  assign w_diff = {1'b0, r_cnt} - LAT;
  assign w_code = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];

  assign w_hs = r_valid & sample_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], comp_in};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (roll_in) begin
            r_state <= S_CONVERT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CONVERT: begin
          if (roll_in) begin
            r_state <= S_HOLD;
            r_data  <= MAXC;
            r_ovr   <= 1'b1;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end else if (w_comp_s) begin
            r_state <= S_HOLD;
            r_data  <= w_code;
            r_ovr   <= 1'b0;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end else if (r_cnt != MAXC) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (w_hs) begin
            r_valid <= 1'b0;
            // A frame starting on the handshake cycle is taken, not dropped.
            if (roll_in) begin
              r_state <= S_CONVERT;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (roll_in) begin
            if (r_drop != 4'hF) begin
              r_drop <= r_drop + 4'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sample_data  = r_data;
  assign sample_valid = r_valid;
  assign overrange    = r_ovr;
  assign busy         = r_busy;
  assign drop_count   = r_drop;

endmodule

// File: tb/tb_ramp_adc_capture.sv
// Self-checking bench for ramp_adc_capture: scoreboard of
// expected {overrange, code} popped on each handshake.
module tb_ramp_adc_capture;

  logic       clk;
  logic       reset_n;
  logic       roll_in;
  logic       comp_in;
  logic [6:0] sample_data;
  logic       sample_valid;
  logic       sample_ready;
  logic       overrange;
  logic       busy;
  logic [3:0] drop_count;

  int n_chk = 0;
  int n_err = 0;
  int vcnt  = 0;
  int v0;

  logic [7:0] q[$];

  ramp_adc_capture #(
    .WIDTH(7),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .roll_in(roll_in),
    .comp_in(comp_in),
    .sample_data(sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrange(overrange),
    .busy(busy),
    .drop_count(drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && sample_valid) begin
      vcnt <= vcnt + 1;
    end
    if (reset_n && sample_valid && sample_ready) begin
      if (q.size() == 0) begin
        check("sb_unexp", q.size(), 1);
      end else begin
        check("sb", {overrange, sample_data}, q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 300; i++) begin
      if (sample_valid) break;
      tick();
    end
    check("wait_valid", sample_valid, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (q.size() == 0 && !sample_valid) break;
      tick();
    end
    check("drain", q.size(), 0);
  endtask

  // Roll, then raise comp_in so it is sampled k cycles after the roll.
  task automatic run_frame(input int k);
    comp_in = 1'b0;
    repeat (3) tick();
    q.push_back({1'b0, 7'(k - 1)});
    roll_in = 1'b1;
    tick();
    roll_in = 1'b0;
    check("conv_busy", busy, 1);
    repeat (k - 1) tick();
    comp_in = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b0;
    roll_in      = 1'b0;
    comp_in      = 1'b0;
    sample_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", sample_data, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_ovr", overrange, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_count, 0);
    reset_n = 1'b1;
    tick();

    sample_ready = 1'b1;
    v0 = vcnt;
    run_frame(41);
    wait_drain();
    check("one_cycle", vcnt - v0, 1);
    run_frame(1);
    wait_drain();
    run_frame(100);
    wait_drain();
    run_frame(3);
    wait_drain();

    comp_in = 1'b0;
    repeat (3) tick();
    q.push_back({1'b1, 7'd127});
    roll_in = 1'b1;
    tick();
    roll_in = 1'b0;
    repeat (127) tick();
    roll_in = 1'b1;
    tick();
    roll_in = 1'b0;
    wait_drain();
    repeat (5) tick();
    check("ovr_idle_busy", busy, 0);
    check("ovr_idle_valid", sample_valid, 0);

    comp_in = 1'b1;
    repeat (3) tick();
    q.push_back({1'b0, 7'd0});
    roll_in = 1'b1;
    tick();
    roll_in = 1'b0;
    wait_drain();

    q.push_back({1'b1, 7'd127});
    roll_in = 1'b1;
    tick();
    tick();
    roll_in = 1'b0;
    wait_drain();

    sample_ready = 1'b0;
    run_frame(41);
    wait_valid();
    comp_in = 1'b0;
    for (int p = 0; p < 20; p++) begin
      roll_in = 1'b1;
      tick();
      roll_in = 1'b0;
      repeat (3) tick();
      if (p == 4) check("drop5", drop_count, 5);
    end
    check("bp_data", sample_data, 40);
    check("bp_valid", sample_valid, 1);
    check("drop_sat", drop_count, 15);
    sample_ready = 1'b1;
    wait_drain();
    repeat (2) tick();
    check("bp_idle", busy, 0);

    comp_in = 1'b0;
    repeat (3) tick();
    roll_in = 1'b1;
    tick();
    roll_in = 1'b0;
    repeat (20) tick();
    check("mid_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", sample_valid, 0);
    check("arst_data", sample_data, 0);
    check("arst_ovr", overrange, 0);
    check("arst_drop", drop_count, 0);
    #5 reset_n = 1'b1;
    v0 = vcnt;
    repeat (150) tick();
    check("arst_novalid", vcnt - v0, 0);

    sample_ready = 1'b0;
    run_frame(11);
    wait_valid();
    comp_in = 1'b0;
    repeat (3) tick();
    q.push_back({1'b0, 7'd20});
    sample_ready = 1'b1;
    roll_in      = 1'b1;
    tick();
    roll_in      = 1'b0;
    sample_ready = 1'b0;
    check("sim_busy", busy, 1);
    check("sim_valid", sample_valid, 0);
    check("sim_drop", drop_count, 0);
    repeat (20) tick();
    comp_in      = 1'b1;
    sample_ready = 1'b1;
    wait_drain();
    check("end_drop", drop_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
